// File: rtl/taylor_horner_seq_if.sv
// Bundle between the register file / datapath resources and the Horner sequencer.
// The sequencer connects through the slave modport; the surrounding logic uses master.
interface taylor_horner_seq_if #(
  parameter int DW = 32,
  parameter int NW = 4
);
  logic              start;
  logic [DW-1:0]     x_in;
  logic [NW-1:0]     order_in;
  logic              busy;
  logic              done;
  logic [DW-1:0]     result;
  logic              ovf;
  logic              coef_rd_en;
  logic [NW-1:0]     coef_addr;
  logic [DW-1:0]     coef_rdata;
  logic              mul_valid;
  logic [DW-1:0]     mul_a;
  logic [DW-1:0]     mul_b;
  logic              mul_pvalid;
  logic [2*DW-1:0]   mul_p;

  modport slave (
    input  start, x_in, order_in, coef_rdata, mul_pvalid, mul_p,
    output busy, done, result, ovf, coef_rd_en, coef_addr, mul_valid, mul_a, mul_b
  );

  modport master (
    output start, x_in, order_in, coef_rdata, mul_pvalid, mul_p,
    input  busy, done, result, ovf, coef_rd_en, coef_addr, mul_valid, mul_a, mul_b
  );
endinterface

// File: rtl/taylor_horner_seq.sv
// Horner-method sequencer for a signed fixed-point Taylor polynomial, driving a
// 1-cycle coefficient RAM and an external pipelined multiplier. All outputs registered.
module taylor_horner_seq #(
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int NW   = 4
) (
  input logic               ACLK,
  input logic               ARESET,
  taylor_horner_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_MUL,
    S_WAIT,
    S_ADD,
    S_DONE
  } state_t;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  state_t            state_q, state_d;
  logic [DW-1:0]     xr_q, xr_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     k_q, k_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [DW-1:0]     creg_q, creg_d;
  logic [2*DW-1:0]   prod_q, prod_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              rd_en_q, rd_en_d;
  logic [NW-1:0]     addr_q, addr_d;
  logic              mvalid_q, mvalid_d;
  logic [DW-1:0]     mul_a_q, mul_a_d;
  logic [DW-1:0]     mul_b_q, mul_b_d;

  // Scale step: arithmetic shift floors toward -inf, then clamp to DW bits.
  logic signed [2*DW-1:0] shifted;
  logic                   scale_clamp;
  logic [DW-1:0]          scaled;
  logic [DW:0]            sum;
  logic                   add_clamp;
  logic [DW-1:0]          acc_new;

  assign shifted     = $signed(prod_q) >>> FRAC;
  assign scale_clamp = !((&shifted[2*DW-1:DW-1]) || !(|shifted[2*DW-1:DW-1]));
  assign scaled      = scale_clamp ? (shifted[2*DW-1] ? SAT_MIN : SAT_MAX) : shifted[DW-1:0];
  assign sum         = {scaled[DW-1], scaled} + {creg_q[DW-1], creg_q};
  assign add_clamp   = sum[DW] != sum[DW-1];
  assign acc_new     = add_clamp ? (sum[DW] ? SAT_MIN : SAT_MAX) : sum[DW-1:0];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      xr_q     <= '0;
      n_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      creg_q   <= '0;
      prod_q   <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      mvalid_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      xr_q     <= xr_d;
      n_q      <= n_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      creg_q   <= creg_d;
      prod_q   <= prod_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      mvalid_q <= mvalid_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  // Outputs are registered, so each strobe is raised on the transition into its state.
  always_comb begin
    state_d  = state_q;
    xr_d     = xr_q;
    n_d      = n_q;
    k_d      = k_q;
    acc_d    = acc_q;
    creg_d   = creg_q;
    prod_d   = prod_q;
    first_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    mvalid_d = 1'b0;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          xr_d    = bus.x_in;
          n_d     = bus.order_in;
          k_d     = bus.order_in;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          addr_d  = bus.order_in;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        acc_d = bus.coef_rdata;
        if (n_q == '0) begin
          done_d   = 1'b1;
          result_d = bus.coef_rdata;
          state_d  = S_DONE;
        end else begin
          mvalid_d = 1'b1;
          mul_a_d  = bus.coef_rdata;
          mul_b_d  = xr_q;
          rd_en_d  = 1'b1;
          addr_d   = k_q - NW'(1);
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        first_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (first_q) creg_d = bus.coef_rdata;
        if (bus.mul_pvalid) begin
          prod_d  = bus.mul_p;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d = acc_new;
        k_d   = k_q - NW'(1);
        ovf_d = ovf_q | scale_clamp | add_clamp;
        if (k_q == NW'(1)) begin
          done_d   = 1'b1;
          result_d = acc_new;
          state_d  = S_DONE;
        end else begin
          mvalid_d = 1'b1;
          mul_a_d  = acc_new;
          mul_b_d  = xr_q;
          rd_en_d  = 1'b1;
          addr_d   = k_q - NW'(2);
          state_d  = S_MUL;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.ovf        = ovf_q;
  assign bus.coef_rd_en = rd_en_q;
  assign bus.coef_addr  = addr_q;
  assign bus.mul_valid  = mvalid_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;

endmodule

// File: tb/tb_taylor_horner_seq.sv
// Randomised bench for taylor_horner_seq: models the coefficient RAM and a
// variable-latency multiplier, and checks results against a plain-arithmetic Horner model.
module tb_taylor_horner_seq;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  taylor_horner_seq_if #(.DW(DW), .NW(NW)) bus_if ();

  taylor_horner_seq #(.DW(DW), .FRAC(16), .NW(NW)) dut (
    .ACLK  (aclk),
    .ARESET(areset),
    .bus   (bus_if.slave)
  );

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [DW-1:0] coef_mem [16];
  int lat = 3;
  int mul_issued = 0;
  bit ref_ovf;

  typedef struct {
    int          due;
    logic [63:0] p;
  } mul_t;
  mul_t mq[$];
  logic [DW-1:0] rd_pending = '0;

  // RAM returns data one cycle after the strobe; multiplier answers lat cycles after issue.
  always @(negedge aclk) begin
    longint pr;
    bus_if.coef_rdata = rd_pending;
    rd_pending = bus_if.coef_rd_en ? coef_mem[bus_if.coef_addr] : $urandom();
    if (bus_if.mul_valid) begin
      mul_issued++;
      pr = longint'($signed(bus_if.mul_a)) * longint'($signed(bus_if.mul_b));
      mq.push_back('{due: cyc + lat, p: pr});
    end
    bus_if.mul_pvalid = 1'b0;
    bus_if.mul_p = {$urandom(), $urandom()};
    if (mq.size() > 0 && mq[0].due == cyc) begin
      bus_if.mul_pvalid = 1'b1;
      bus_if.mul_p = mq[0].p;
      void'(mq.pop_front());
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > SMAX) begin ref_ovf = 1'b1; return SMAX; end
    if (v < SMIN) begin ref_ovf = 1'b1; return SMIN; end
    return v;
  endfunction

  function automatic void ref_eval(input logic signed [31:0] x, input int n,
                                   output logic signed [31:0] res, output bit ov);
    longint acc;
    longint xs;
    ref_ovf = 1'b0;
    acc = longint'(coef_mem[n]);
    xs = longint'(x);
    for (int k = n; k >= 1; k--) begin
      acc = sat32((acc * xs) >>> 16);
      acc = sat32(acc + longint'(coef_mem[k-1]));
    end
    res = 32'(acc);
    ov = ref_ovf;
  endfunction

  task automatic run_eval(input logic signed [31:0] x, input int n, input int l,
                          input int extra_at, input logic [31:0] x2);
    logic signed [31:0] exp_res;
    bit exp_ovf;
    int done_off;
    bit busy_ok;
    int stray;
    lat = l;
    ref_eval(x, n, exp_res, exp_ovf);
    @(negedge aclk);
    mul_issued = 0;
    bus_if.start = 1'b1;
    bus_if.x_in = x;
    bus_if.order_in = NW'(n);
    done_off = -1;
    busy_ok = 1'b1;
    for (int off = 1; off <= 400; off++) begin
      @(negedge aclk);
      if (off == extra_at) begin
        bus_if.start = 1'b1;
        bus_if.x_in = x2;
        bus_if.order_in = NW'($urandom_range(1, 15));
      end else begin
        bus_if.start = 1'b0;
      end
      if (off == 1) chk("ovf_clear", bus_if.ovf, 0);
      if (!bus_if.busy) busy_ok = 1'b0;
      if (bus_if.done) begin
        done_off = off;
        break;
      end
    end
    bus_if.start = 1'b0;
    chk("done_latency", done_off, 3 + n * (l + 2));
    chk("busy_high", busy_ok, 1);
    chk("result", longint'($signed(bus_if.result)), longint'(exp_res));
    chk("ovf", bus_if.ovf, exp_ovf);
    $display("eval x=%h n=%0d L=%0d -> result=%h ovf=%0d done@+%0d",
             x, n, l, bus_if.result, bus_if.ovf, done_off);
    @(negedge aclk);
    chk("done_pulse", bus_if.done, 0);
    chk("busy_clear", bus_if.busy, 0);
    chk("ovf_sticky", bus_if.ovf, exp_ovf);
    chk("mul_count", mul_issued, n);
    if (extra_at > 0) begin
      stray = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge aclk);
        if (bus_if.busy || bus_if.done) stray++;
      end
      chk("no_second_eval", stray, 0);
    end
  endtask

  task automatic clear_coefs();
    for (int i = 0; i < 16; i++) coef_mem[i] = '0;
  endtask

  initial begin
    int stray;
    int n;
    logic signed [31:0] x;
    bus_if.start = 1'b0;
    bus_if.x_in = '0;
    bus_if.order_in = '0;
    clear_coefs();

    repeat (3) @(negedge aclk);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_done", bus_if.done, 0);
    chk("rst_result", bus_if.result, 0);
    chk("rst_rd_en", bus_if.coef_rd_en, 0);
    chk("rst_mul_valid", bus_if.mul_valid, 0);
    areset = 1'b0;

    // exp(x) approximation at x=1
    coef_mem[0] = 32'h00010000; coef_mem[1] = 32'h00010000; coef_mem[2] = 32'h00008000;
    run_eval(32'h00010000, 2, 3, 0, '0);

    clear_coefs();
    coef_mem[0] = 32'h12345678;
    run_eval($urandom(), 0, 2, 0, '0);

    clear_coefs();
    coef_mem[1] = 32'h00000001;
    run_eval(32'hFFFF8000, 1, 1, 0, '0);

    clear_coefs();
    coef_mem[0] = 32'h00010000; coef_mem[1] = 32'h7FFF0000;
    run_eval(32'h00020000, 1, 2, 0, '0);
    coef_mem[0] = 32'h00010000; coef_mem[1] = 32'h00010000; coef_mem[2] = 32'h00008000;
    run_eval(32'h00010000, 2, 3, 0, '0);

    // second start during an evaluation
    run_eval(32'h00010000, 2, 3, 5, 32'h00030000);

    // reset while waiting on the multiplier
    lat = 10;
    @(negedge aclk);
    bus_if.start = 1'b1;
    bus_if.x_in = 32'h00010000;
    bus_if.order_in = 4'd2;
    @(negedge aclk);
    bus_if.start = 1'b0;
    repeat (5) @(negedge aclk);
    areset = 1'b1;
    #1;
    chk("mid_rst_busy", bus_if.busy, 0);
    chk("mid_rst_done", bus_if.done, 0);
    chk("mid_rst_result", bus_if.result, 0);
    chk("mid_rst_ovf", bus_if.ovf, 0);
    chk("mid_rst_rd_en", bus_if.coef_rd_en, 0);
    chk("mid_rst_addr", bus_if.coef_addr, 0);
    chk("mid_rst_mul_valid", bus_if.mul_valid, 0);
    chk("mid_rst_mul_a", bus_if.mul_a, 0);
    chk("mid_rst_mul_b", bus_if.mul_b, 0);
    @(negedge aclk);
    areset = 1'b0;
    stray = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge aclk);
      if (bus_if.busy || bus_if.done) stray++;
    end
    chk("late_pvalid_ignored", stray, 0);
    chk("mul_queue_drained", mq.size(), 0);
    run_eval(32'h00010000, 2, 4, 0, '0);

    // randomised evaluations
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) coef_mem[i] = $urandom();
        else coef_mem[i] = $signed(32'($urandom_range(0, 2097152))) - 32'sd1048576;
      end
      n = $urandom_range(0, 15);
      x = $signed(32'($urandom_range(0, 262143))) - 32'sd131072;
      run_eval(x, n, $urandom_range(1, 5), 0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
